// File: rtl/riscv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the multi-cycle RV32I control unit:
//   - state_t     : FSM state encoding (0..10, FETCH first)
//   - OP_*        : opcodes the control unit recognises
//   - select enums: ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, ALUOp
//   - ctrl_t      : per-state Moore control word held in the FSM register
//   - helpers     : per-state control decode, immediate-format decode,
//                   opcode legality check
// ---------------------------------------------------------------------------
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [1:0] {
      RES_ALUOUT    = 2'b00,
      RES_DATA      = 2'b01,
      RES_ALURESULT = 2'b10
   } result_src_t;

   typedef enum logic [1:0] {
      SRCA_PC    = 2'b00,
      SRCA_OLDPC = 2'b01,
      SRCA_REGA  = 2'b10
   } alu_src_a_t;

   typedef enum logic [1:0] {
      SRCB_REGB = 2'b00,
      SRCB_IMM  = 2'b01,
      SRCB_FOUR = 2'b10
   } alu_src_b_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_src_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

   // The *OnReady / *OnZero flags mark strobes that are qualified by a live
   // input in that state; the plain flags are unconditional for the state.
   typedef struct packed {
      logic        pcWrite;
      logic        pcWriteOnReady;
      logic        pcWriteOnZero;
      logic        irWriteOnReady;
      logic        adrSrc;
      logic        memWrite;
      logic        regWrite;
      logic        immFromOp;
      result_src_t resultSrc;
      alu_src_a_t  aluSrcA;
      alu_src_b_t  aluSrcB;
      alu_op_t     aluOp;
   } ctrl_t;

   // Moore control word for a state; anything not set stays 0.
   function automatic ctrl_t stateControls(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.pcWriteOnReady = 1'b1;
            c.irWriteOnReady = 1'b1;
            c.aluSrcB        = SRCB_FOUR;
            c.resultSrc      = RES_ALURESULT;
         end
         S_DECODE: begin
            c.aluSrcA   = SRCA_OLDPC;
            c.aluSrcB   = SRCB_IMM;
            c.immFromOp = 1'b1;
         end
         S_MEMADR: begin
            c.aluSrcA   = SRCA_REGA;
            c.aluSrcB   = SRCB_IMM;
            c.immFromOp = 1'b1;
         end
         S_MEMREAD:  c.adrSrc = 1'b1;
         S_MEMWB: begin
            c.resultSrc = RES_DATA;
            c.regWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            c.adrSrc   = 1'b1;
            c.memWrite = 1'b1;
         end
         S_EXECUTER: begin
            c.aluSrcA = SRCA_REGA;
            c.aluOp   = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            c.aluSrcA = SRCA_REGA;
            c.aluSrcB = SRCB_IMM;
            c.aluOp   = ALUOP_FUNCT;
         end
         S_ALUWB:    c.regWrite = 1'b1;
         S_JAL: begin
            c.aluSrcA = SRCA_OLDPC;
            c.aluSrcB = SRCB_FOUR;
            c.pcWrite = 1'b1;
         end
         S_BEQ: begin
            c.aluSrcA       = SRCA_REGA;
            c.aluOp         = ALUOP_SUB;
            c.pcWriteOnZero = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Immediate format implied by the opcode; unknown opcodes fall to I.
   function automatic imm_src_t immFromOpcode(input logic [6:0] op);
      imm_src_t imm;
      case (op)
         OP_SW:   imm = IMM_S;
         OP_BEQ:  imm = IMM_B;
         OP_JAL:  imm = IMM_J;
         default: imm = IMM_I;
      endcase
      return imm;
   endfunction

   function automatic logic isLegalOpcode(input logic [6:0] op);
      return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
             (op == OP_I) || (op == OP_JAL) || (op == OP_BEQ);
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm_if
// Control <-> datapath bundle for the multi-cycle core.
//   i_*  : IR fields, ALU zero flag and memory-ready handshake (datapath side)
//   o_*  : every datapath mux select and write strobe (control side)
// Modports: master = control unit, slave = datapath.
// ---------------------------------------------------------------------------
interface multicycle_control_fsm_if;

   logic [6:0] i_Opcode;
   logic [2:0] i_Funct3;
   logic       i_Funct7b5;
   logic       i_Zero;
   logic       i_MemReady;

   logic       o_PCWrite;
   logic       o_AdrSrc;
   logic       o_MemWrite;
   logic       o_IRWrite;
   logic       o_RegWrite;
   logic [1:0] o_ResultSrc;
   logic [1:0] o_ALUSrcA;
   logic [1:0] o_ALUSrcB;
   logic [2:0] o_ALUControl;
   logic [1:0] o_ImmSrc;

   modport master (
      input  i_Opcode, i_Funct3, i_Funct7b5, i_Zero, i_MemReady,
      output o_PCWrite, o_AdrSrc, o_MemWrite, o_IRWrite, o_RegWrite,
             o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ALUControl, o_ImmSrc
   );

   modport slave (
      output i_Opcode, i_Funct3, i_Funct7b5, i_Zero, i_MemReady,
      input  o_PCWrite, o_AdrSrc, o_MemWrite, o_IRWrite, o_RegWrite,
             o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ALUControl, o_ImmSrc
   );

endinterface

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational ALU operation select.
//   i_OpBit5     : opcode bit 5 (1 = R-type, 0 = I-type arithmetic)
//   i_Funct3     : IR[14:12]
//   i_Funct7b5   : IR[30]
//   i_ALUOp      : 00 add, 01 sub, 10 decode from funct fields
//   o_ALUControl : ALU operation
// ---------------------------------------------------------------------------
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic       i_OpBit5,
   input  logic [2:0] i_Funct3,
   input  logic       i_Funct7b5,
   input  alu_op_t    i_ALUOp,
   output alu_ctrl_t  o_ALUControl
);

   // Subtract on funct3=000 only for R-type: for addi, IR[30] is an
   // immediate bit and must not turn the add into a subtract.
   always_comb begin
      o_ALUControl = ALU_ADD;
      case (i_ALUOp)
         ALUOP_SUB:   o_ALUControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (i_Funct3)
               3'b000:  o_ALUControl = (i_OpBit5 & i_Funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  o_ALUControl = ALU_SLT;
               3'b110:  o_ALUControl = ALU_OR;
               3'b111:  o_ALUControl = ALU_AND;
               default: o_ALUControl = ALU_ADD;
            endcase
         end
         default:     o_ALUControl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
// Control unit for the multi-cycle RV32I core.
//   i_Clk     : system clock, rising edge
//   i_Reset   : asynchronous, active-low reset
//   bus       : control/datapath bundle (master side)
//   o_Illegal : one-cycle pulse when DECODE sees an unsupported opcode
//   o_State   : current state encoding, for debug
//   o_Retired : retired-instruction count, wraps at 2^CNT_W
// ---------------------------------------------------------------------------
module multicycle_control_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 32
)
(
   input  logic                        i_Clk,
   input  logic                        i_Reset,
   multicycle_control_fsm_if.master    bus,
   output logic                        o_Illegal,
   output logic [3:0]                  o_State,
   output logic [CNT_W-1:0]            o_Retired
);

   state_t           r_State;
   state_t           w_NextState;
   ctrl_t            r_Ctrl;
   logic [CNT_W-1:0] r_Retired;
   logic             w_Legal;
   logic             w_Retire;
   alu_ctrl_t        w_ALUControl;

   assign w_Legal = isLegalOpcode(bus.i_Opcode);

   // Next-state selection. FETCH, MEMREAD and MEMWRITE stall on the memory
   // handshake; DECODE dispatches on opcode and sends unknown opcodes
   // straight back to FETCH.
   always_comb begin
      w_NextState = r_State;
      case (r_State)
         S_FETCH:    if (bus.i_MemReady) w_NextState = S_DECODE;
         S_DECODE: begin
            case (bus.i_Opcode)
               OP_LW, OP_SW: w_NextState = S_MEMADR;
               OP_R:         w_NextState = S_EXECUTER;
               OP_I:         w_NextState = S_EXECUTEI;
               OP_JAL:       w_NextState = S_JAL;
               OP_BEQ:       w_NextState = S_BEQ;
               default:      w_NextState = S_FETCH;
            endcase
         end
         S_MEMADR:   w_NextState = (bus.i_Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (bus.i_MemReady) w_NextState = S_MEMWB;
         S_MEMWB:    w_NextState = S_FETCH;
         S_MEMWRITE: if (bus.i_MemReady) w_NextState = S_FETCH;
         S_EXECUTER, S_EXECUTEI, S_JAL: w_NextState = S_ALUWB;
         S_ALUWB, S_BEQ:                w_NextState = S_FETCH;
         default:    w_NextState = S_FETCH;
      endcase
   end

   // An instruction retires on the step back into FETCH from one of its
   // completing states; the DECODE -> FETCH illegal path is excluded.
   assign w_Retire = (w_NextState == S_FETCH) &&
                     (r_State inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ});

   // State register with the Moore control word registered alongside it,
   // decoded from the state being entered so it lines up with r_State.
   // Reset abandons any instruction in flight and clears the counter.
   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         r_State   <= S_FETCH;
         r_Ctrl    <= stateControls(S_FETCH);
         r_Retired <= '0;
      end else begin
         r_State <= w_NextState;
         r_Ctrl  <= stateControls(w_NextState);
         if (w_Retire) begin
            r_Retired <= r_Retired + 1'b1;
         end
      end
   end

   alu_decoder u_aluDecoder (
      .i_OpBit5     (bus.i_Opcode[5]),
      .i_Funct3     (bus.i_Funct3),
      .i_Funct7b5   (bus.i_Funct7b5),
      .i_ALUOp      (r_Ctrl.aluOp),
      .o_ALUControl (w_ALUControl)
   );

   // Strobes are qualified by i_Reset so nothing fires while reset is held,
   // even though FETCH's PCWrite/IRWrite follow i_MemReady combinationally.
   assign bus.o_PCWrite    = i_Reset & (r_Ctrl.pcWrite |
                                        (r_Ctrl.pcWriteOnReady & bus.i_MemReady) |
                                        (r_Ctrl.pcWriteOnZero  & bus.i_Zero));
   assign bus.o_IRWrite    = i_Reset & r_Ctrl.irWriteOnReady & bus.i_MemReady;
   assign bus.o_MemWrite   = i_Reset & r_Ctrl.memWrite;
   assign bus.o_RegWrite   = i_Reset & r_Ctrl.regWrite;
   assign bus.o_AdrSrc     = r_Ctrl.adrSrc;
   assign bus.o_ResultSrc  = r_Ctrl.resultSrc;
   assign bus.o_ALUSrcA    = r_Ctrl.aluSrcA;
   assign bus.o_ALUSrcB    = r_Ctrl.aluSrcB;
   assign bus.o_ALUControl = w_ALUControl;
   assign bus.o_ImmSrc     = r_Ctrl.immFromOp ? immFromOpcode(bus.i_Opcode) : IMM_I;

   assign o_Illegal = i_Reset & (r_State == S_DECODE) & ~w_Legal;
   assign o_State   = r_State;
   assign o_Retired = r_Retired;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
// Self-checking bench for multicycle_control_fsm. Each instruction is turned
// into a script of expected states (with memory waits) derived from the
// instruction class, and every cycle's outputs are compared with what that
// state and the instruction fields should produce.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

   localparam int ST_FETCH    = 0;
   localparam int ST_DECODE   = 1;
   localparam int ST_MEMADR   = 2;
   localparam int ST_MEMREAD  = 3;
   localparam int ST_MEMWB    = 4;
   localparam int ST_MEMWRITE = 5;
   localparam int ST_EXECUTER = 6;
   localparam int ST_EXECUTEI = 7;
   localparam int ST_ALUWB    = 8;
   localparam int ST_JAL      = 9;
   localparam int ST_BEQ      = 10;

   localparam logic [6:0] LW   = 7'b0000011;
   localparam logic [6:0] SW   = 7'b0100011;
   localparam logic [6:0] RT   = 7'b0110011;
   localparam logic [6:0] IT   = 7'b0010011;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] BEQ  = 7'b1100011;

   logic        clk;
   logic        rst;
   logic        illegal;
   logic [3:0]  state;
   logic [31:0] retired;

   int checks   = 0;
   int failures = 0;
   int expRetired = 0;

   int   stQ[$];
   logic rdyQ[$];

   multicycle_control_fsm_if bus ();

   multicycle_control_fsm #(.CNT_W(32)) dut (
      .i_Clk     (clk),
      .i_Reset   (rst),
      .bus       (bus),
      .o_Illegal (illegal),
      .o_State   (state),
      .o_Retired (retired)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   function automatic bit isLegal(input logic [6:0] op);
      return (op == LW) || (op == SW) || (op == RT) || (op == IT) ||
             (op == JAL) || (op == BEQ);
   endfunction

   // {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, Illegal}
   function automatic logic [5:0] expStrobes(input int st, input logic rdy,
                                             input logic z, input bit legal);
      logic pc, ir, mw, rw, adr, ill;
      pc  = ((st == ST_FETCH) && rdy) || (st == ST_JAL) || ((st == ST_BEQ) && z);
      ir  = (st == ST_FETCH) && rdy;
      mw  = (st == ST_MEMWRITE);
      rw  = (st == ST_MEMWB) || (st == ST_ALUWB);
      adr = (st == ST_MEMREAD) || (st == ST_MEMWRITE);
      ill = (st == ST_DECODE) && !legal;
      return {pc, ir, mw, rw, adr, ill};
   endfunction

   // {ResultSrc, ALUSrcA, ALUSrcB}
   function automatic logic [5:0] expSelects(input int st);
      case (st)
         ST_FETCH:    return 6'b10_00_10;
         ST_DECODE:   return 6'b00_01_01;
         ST_MEMADR:   return 6'b00_10_01;
         ST_MEMWB:    return 6'b01_00_00;
         ST_EXECUTER: return 6'b00_10_00;
         ST_EXECUTEI: return 6'b00_10_01;
         ST_JAL:      return 6'b00_01_10;
         ST_BEQ:      return 6'b00_10_00;
         default:     return 6'b00_00_00;
      endcase
   endfunction

   function automatic logic [2:0] expAlu(input int st, input logic [2:0] f3,
                                         input logic f7);
      if (st == ST_BEQ) return 3'b001;
      if ((st == ST_EXECUTER) || (st == ST_EXECUTEI)) begin
         case (f3)
            3'b000:  return ((st == ST_EXECUTER) && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
         endcase
      end
      return 3'b000;
   endfunction

   function automatic logic [1:0] expImm(input int st, input logic [6:0] op);
      if ((st != ST_DECODE) && (st != ST_MEMADR)) return 2'b00;
      if (op == SW)  return 2'b01;
      if (op == BEQ) return 2'b10;
      if (op == JAL) return 2'b11;
      return 2'b00;
   endfunction

   task automatic addStep(input int st, input logic rdy);
      stQ.push_back(st);
      rdyQ.push_back(rdy);
   endtask

   // Runs one instruction through its expected state script. fetchWait and
   // memWait are memory stall cycles; abortAt >= 0 pulls reset during that
   // step instead of completing the instruction.
   task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                input logic f7, input logic z,
                                input int fetchWait, input int memWait,
                                input int abortAt);
      bit legal;
      string tag;
      legal = isLegal(op);
      stQ.delete();
      rdyQ.delete();
      for (int i = 0; i < fetchWait; i++) addStep(ST_FETCH, 1'b0);
      addStep(ST_FETCH, 1'b1);
      addStep(ST_DECODE, 1'($urandom_range(0, 1)));
      if (op == LW) begin
         addStep(ST_MEMADR, 1'($urandom_range(0, 1)));
         for (int i = 0; i < memWait; i++) addStep(ST_MEMREAD, 1'b0);
         addStep(ST_MEMREAD, 1'b1);
         addStep(ST_MEMWB, 1'($urandom_range(0, 1)));
      end else if (op == SW) begin
         addStep(ST_MEMADR, 1'($urandom_range(0, 1)));
         for (int i = 0; i < memWait; i++) addStep(ST_MEMWRITE, 1'b0);
         addStep(ST_MEMWRITE, 1'b1);
      end else if (op == RT) begin
         addStep(ST_EXECUTER, 1'($urandom_range(0, 1)));
         addStep(ST_ALUWB, 1'($urandom_range(0, 1)));
      end else if (op == IT) begin
         addStep(ST_EXECUTEI, 1'($urandom_range(0, 1)));
         addStep(ST_ALUWB, 1'($urandom_range(0, 1)));
      end else if (op == JAL) begin
         addStep(ST_JAL, 1'($urandom_range(0, 1)));
         addStep(ST_ALUWB, 1'($urandom_range(0, 1)));
      end else if (op == BEQ) begin
         addStep(ST_BEQ, 1'($urandom_range(0, 1)));
      end

      bus.i_Opcode   = op;
      bus.i_Funct3   = f3;
      bus.i_Funct7b5 = f7;
      bus.i_Zero     = z;

      for (int k = 0; k < stQ.size(); k++) begin
         bus.i_MemReady = rdyQ[k];
         #1;
         tag = $sformatf("op=%b step=%0d st=%0d", op, k, stQ[k]);
         checkOutput({tag, " state"}, 32'(state), 32'(stQ[k]));
         checkOutput({tag, " strobes"},
                     32'({bus.o_PCWrite, bus.o_IRWrite, bus.o_MemWrite,
                          bus.o_RegWrite, bus.o_AdrSrc, illegal}),
                     32'(expStrobes(stQ[k], rdyQ[k], z, legal)));
         checkOutput({tag, " selects"},
                     32'({bus.o_ResultSrc, bus.o_ALUSrcA, bus.o_ALUSrcB}),
                     32'(expSelects(stQ[k])));
         checkOutput({tag, " aluctl"}, 32'(bus.o_ALUControl),
                     32'(expAlu(stQ[k], f3, f7)));
         checkOutput({tag, " immsrc"}, 32'(bus.o_ImmSrc), 32'(expImm(stQ[k], op)));
         if (k == abortAt) begin
            rst = 1'b0;
            bus.i_MemReady = 1'b1;
            #1;
            expRetired = 0;
            checkOutput("abort state", 32'(state), ST_FETCH);
            checkOutput("abort strobes",
                        32'({bus.o_PCWrite, bus.o_IRWrite, bus.o_MemWrite,
                             bus.o_RegWrite, illegal}), 32'd0);
            checkOutput("abort retired", retired, 32'(expRetired));
            bus.i_MemReady = 1'b0;
            #1 rst = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("abort resume state", 32'(state), ST_FETCH);
            return;
         end
         @(posedge clk);
         #1;
      end

      if (legal) expRetired++;
      checkOutput($sformatf("op=%b retired", op), retired, 32'(expRetired));
      checkOutput($sformatf("op=%b back to fetch", op), 32'(state), ST_FETCH);
   endtask

   initial begin
      logic [6:0] legalOps [6];
      logic [6:0] op;
      legalOps = '{LW, SW, RT, IT, JAL, BEQ};

      // Reset held with the handshake high: FETCH would otherwise strobe.
      rst            = 1'b0;
      bus.i_Opcode   = 7'd0;
      bus.i_Funct3   = 3'd0;
      bus.i_Funct7b5 = 1'b0;
      bus.i_Zero     = 1'b1;
      bus.i_MemReady = 1'b1;
      #2;
      checkOutput("reset state", 32'(state), ST_FETCH);
      checkOutput("reset retired", retired, 32'd0);
      checkOutput("reset strobes",
                  32'({bus.o_PCWrite, bus.o_IRWrite, bus.o_MemWrite,
                       bus.o_RegWrite, illegal}), 32'd0);
      #6 rst = 1'b1;

      // Directed cases.
      applyStimulus(LW,  3'b010, 1'b0, 1'b0, 0, 0, -1);
      applyStimulus(SW,  3'b010, 1'b0, 1'b0, 0, 3, -1);
      applyStimulus(RT,  3'b000, 1'b1, 1'b0, 0, 0, -1);
      applyStimulus(RT,  3'b111, 1'b0, 1'b0, 0, 0, -1);
      applyStimulus(IT,  3'b000, 1'b1, 1'b0, 0, 0, -1);
      applyStimulus(JAL, 3'b000, 1'b0, 1'b0, 1, 0, -1);
      applyStimulus(BEQ, 3'b000, 1'b0, 1'b1, 0, 0, -1);
      applyStimulus(BEQ, 3'b000, 1'b0, 1'b0, 0, 0, -1);
      applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, -1);
      applyStimulus(LW,  3'b010, 1'b0, 1'b0, 0, 2, 3);
      applyStimulus(LW,  3'b010, 1'b0, 1'b0, 2, 1, -1);

      // Randomised instruction mix, including illegal opcodes and stalls.
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 6) == 0) begin
            do op = 7'($urandom); while (isLegal(op));
         end else begin
            op = legalOps[$urandom_range(0, 5)];
         end
         applyStimulus(op, 3'($urandom), 1'($urandom), 1'($urandom),
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
